// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO, with modelled multi-cycle latency.
// Optional madd/maddu accumulate support is enabled by defining HILO_MDU_MADD_EN.
module hilo_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  HILO_op,
    input  logic        start,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HILO_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MTHI = 4'b0010;
    localparam logic [3:0] OP_MTLO = 4'b0011;

    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;
    logic          pend_acc_q, pend_acc_d;

    logic          accept;
    logic          op_signed;
    logic          is_mul;
    logic          is_div;
    logic          is_madd;

    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
    logic [63:0]        prod;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;

    // Bit 1 selects the signed flavour; bit 0 separates divide from multiply.
    assign op_signed = HILO_op[1];
    assign is_mul    = (HILO_op[3:2] == 2'b01) && !HILO_op[0];
    assign is_div    = (HILO_op[3:2] == 2'b01) &&  HILO_op[0];

`ifdef HILO_MDU_MADD_EN
    assign is_madd   = (HILO_op[3:2] == 2'b11) && !HILO_op[0];
`else
    assign is_madd   = 1'b0;
`endif

    assign busy   = (cnt_q != '0);
    assign accept = !req && !busy;

    always_comb begin
        s_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        u_prod = {32'b0, A} * {32'b0, B};
        prod   = op_signed ? $unsigned(s_prod) : u_prod;
    end

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of hitting the host-level overflow case.
    always_comb begin
        a_neg    = op_signed && A[31];
        b_neg    = op_signed && B[31];
        a_mag    = a_neg ? (32'd0 - A) : A;
        b_mag    = b_neg ? (32'd0 - B) : B;
        div_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag    = a_mag / div_safe;
        r_mag    = a_mag % div_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_wr_d  = pend_wr_q;
        pend_acc_d = pend_acc_q;

        if (busy) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && pend_wr_q) begin
                if (pend_acc_q) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
                end else begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (accept) begin
            if (start) begin
                if (is_mul || is_madd) begin
                    cnt_d      = MULT_LOAD;
                    {pend_hi_d, pend_lo_d} = prod;
                    pend_wr_d  = 1'b1;
                    pend_acc_d = is_madd;
                end else if (is_div) begin
                    cnt_d      = DIV_LOAD;
                    pend_hi_d  = rem;
                    pend_lo_d  = quot;
                    pend_wr_d  = (B != 32'd0);
                    pend_acc_d = 1'b0;
                end
            end else if (HILO_op == OP_MTHI) begin
                hi_d = A;
            end else if (HILO_op == OP_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_wr_q  <= 1'b0;
            pend_acc_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_wr_q  <= pend_wr_d;
            pend_acc_q <= pend_acc_d;
        end
    end

    // Reads see committed state only; pending results stay invisible until commit.
    assign HILO_out = HILO_op[0] ? lo_q : hi_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu: latency, arithmetic, flush, reset, madd.
module tb_hilo_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  hilo_op;
  logic        start;
  logic        req;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;
  int n_busy;

  hilo_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .HILO_op  (hilo_op),
    .start    (start),
    .req      (req),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .HILO_out (hilo_out),
    .HI       (hi),
    .LO       (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one operation for one edge, then return inputs to idle (mfhi, no start).
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic st, input logic rq);
    @(negedge clk);
    hilo_op = op;
    a       = av;
    b       = bv;
    start   = st;
    req     = rq;
    @(negedge clk);
    hilo_op = 4'b0000;
    start   = 1'b0;
    req     = 1'b0;
  endtask

  // Count busy cycles, starting at the first negedge after the start edge.
  task automatic count_busy(input int already, output int n);
    n = already;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_cycles);
    int n;
    issue(op, av, bv, 1'b1, 1'b0);
    count_busy(0, n);
    check({tag, "_busy_len"}, n, exp_cycles);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    hilo_op  = 4'b0000;
    start    = 1'b0;
    req      = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check_hilo("reset", 32'h0, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_out", hilo_out, 32'h0);

    // signed mult -3 * 5 = -15
    check("pre_mult_busy", {31'b0, busy}, 32'd0);
    run_op("mult", 4'b0110, 32'hFFFF_FFFD, 32'd5, 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    hilo_op = 4'b0001;
    #1 check("mflo_out", hilo_out, 32'hFFFF_FFF1);
    hilo_op = 4'b0000;
    #1 check("mfhi_out", hilo_out, 32'hFFFF_FFFF);

    // unsigned mult 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
    run_op("multu", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // signed div -7 / 2 = -3 rem -1
    run_op("div", 4'b0111, 32'hFFFF_FFF9, 32'd2, 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // unsigned div 7 / 2 = 3 rem 1
    run_op("divu", 4'b0101, 32'd7, 32'd2, 10);
    check_hilo("divu", 32'd1, 32'd3);

    // overflow corner
    run_op("div_ovf", 4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    // mthi / mtlo then divide by zero leaves HI/LO alone
    issue(4'b0010, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    issue(4'b0011, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
    check_hilo("mt", 32'h1234, 32'h5678);
    run_op("div0", 4'b0111, 32'd99, 32'd0, 10);
    check_hilo("div0", 32'h1234, 32'h5678);

    // flush suppression
    issue(4'b0010, 32'h0000_DEAD, 32'd0, 1'b0, 1'b1);
    check_hilo("mthi_req", 32'h1234, 32'h5678);
    issue(4'b0110, 32'd3, 32'd3, 1'b1, 1'b1);
    check("mult_req_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check_hilo("mult_req", 32'h1234, 32'h5678);

    // reset on the third busy cycle discards the operation
    issue(4'b0110, 32'd2, 32'd3, 1'b1, 1'b0);
    check("rst_mid_busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check_hilo("rst_mid", 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    check("rst_late_busy", {31'b0, busy}, 32'd0);
    check_hilo("rst_late", 32'h0, 32'h0);

    // second start and an mthi while busy are both ignored
    issue(4'b0110, 32'd2, 32'd3, 1'b1, 1'b0);
    check("busy_first", {31'b0, busy}, 32'd1);
    hilo_op = 4'b0110;
    a       = 32'd7;
    b       = 32'd7;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    hilo_op = 4'b0010;
    a       = 32'h0000_BEEF;
    @(negedge clk);
    hilo_op = 4'b0000;
    count_busy(2, n_busy);
    check("restart_busy_len", n_busy, 32'd5);
    check_hilo("restart", 32'h0, 32'd6);

    // multiply-accumulate
    issue(4'b0010, 32'h0, 32'd0, 1'b0, 1'b0);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
`ifdef HILO_MDU_MADD_EN
    run_op("madd", 4'b1110, 32'd1, 32'd1, 5);
    check_hilo("madd", 32'd1, 32'd0);
    run_op("maddu", 4'b1100, 32'hFFFF_FFFF, 32'd2, 5);
    check_hilo("maddu", 32'd2, 32'hFFFF_FFFE);
    run_op("madd_neg", 4'b1110, 32'hFFFF_FFFF, 32'd2, 5);
    check_hilo("madd_neg", 32'd2, 32'hFFFF_FFFC);
`else
    issue(4'b1110, 32'd1, 32'd1, 1'b1, 1'b0);
    check("madd_off_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check_hilo("madd_off", 32'h0, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
